mem_pipe_rtl: RTL and testbench

// - Parametrised successor of the single-port memory model: byte-strobed writes, a configurable

---
 rtl/mem_pipe_rtl.sv | 181 ++++++++++++++++++
 tb/tb_mem_pipe_rtl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_pipe_rtl.sv
// mem_pipe_rtl: synchronous RAM slave with byte-strobed writes, a fixed
// RD_LATENCY response pipeline and in-order status codes
// (00 OK, 01 OUT_OF_RANGE, 10 PARITY, 11 ILLEGAL).
// Optional feature: define MEM_PARITY_EN to store one even-parity bit per
// byte and add the test-only inj_par_err input.
// Handshake: a request is accepted on a rising edge where ready & (wr|rd);
// ready is never withdrawn in RUN, so there is no back-pressure. Each accepted
// request yields exactly one resp_valid pulse RD_LATENCY cycles later.
module mem_pipe_rtl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_SIZE   = 16,
   parameter int RD_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    wr,
   input  logic                    rd,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
`ifdef MEM_PARITY_EN
   input  logic                    inj_par_err,
`endif
   output logic                    ready,
   output logic                    resp_valid,
   output logic                    resp_is_rd,
   output logic [1:0]              resp,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int NB   = DATA_WIDTH / 8;
   localparam int IDXW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

   typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_RUN} state_t;

   state_t                  state_q;
   logic                    ready_q;
   logic [DATA_WIDTH-1:0]   mem_q [MEM_SIZE];
`ifdef MEM_PARITY_EN
   logic [NB-1:0]           par_q [MEM_SIZE];
`endif

   // Response pipeline: stage RD_LATENCY-1 drives the outputs.
   logic                    pv_q    [RD_LATENCY];
   logic                    prd_q   [RD_LATENCY];
   logic [1:0]              pcode_q [RD_LATENCY];
   logic [DATA_WIDTH-1:0]   pdata_q [RD_LATENCY];

   // Next value entering each stage.
   logic                    in_v    [RD_LATENCY];
   logic                    in_rd   [RD_LATENCY];
   logic [1:0]              in_code [RD_LATENCY];
   logic [DATA_WIDTH-1:0]   in_data [RD_LATENCY];

   logic [IDXW-1:0]         idx;
   logic                    in_range;
   logic                    acc;
   logic                    do_write;
   logic                    par_bad;
   logic                    req_rd;
   logic [1:0]              req_code;
   logic [DATA_WIDTH-1:0]   req_data;

   // Lifecycle FSM: RESET -> INIT -> RUN; ready is registered and high only in RUN.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_RESET;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RESET: begin
               state_q <= ST_INIT;
               ready_q <= 1'b0;
            end
            ST_INIT: begin
               state_q <= ST_RUN;
               ready_q <= 1'b1;
            end
            ST_RUN: begin
               state_q <= ST_RUN;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_RESET;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Decode the request presented this cycle into a status code and read data.
   always_comb begin
      idx      = addr[IDXW-1:0];
      in_range = (32'(addr) < 32'(MEM_SIZE));
      acc      = ready_q & (wr | rd);
      do_write = acc & wr & ~rd & in_range;
      req_rd   = acc & rd & ~wr;
      par_bad  = 1'b0;
`ifdef MEM_PARITY_EN
      for (int b = 0; b < NB; b++) begin
         if ((^mem_q[idx][8*b +: 8]) != par_q[idx][b]) par_bad = 1'b1;
      end
`endif
      req_code = 2'b00;
      req_data = '0;
      if (acc) begin
         if (wr && rd) begin
            req_code = 2'b11;
         end else if (!in_range) begin
            req_code = 2'b01;
         end else if (rd) begin
            req_data = mem_q[idx];
            if (par_bad) req_code = 2'b10;
         end
      end
   end

   // Memory array (and parity bits): cleared on reset, byte-strobed write at accept.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < MEM_SIZE; i++) begin
            mem_q[i] <= '0;
`ifdef MEM_PARITY_EN
            par_q[i] <= '0;
`endif
         end
      end else if (do_write) begin
         for (int b = 0; b < NB; b++) begin
            if (wstrb[b]) begin
               mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
`ifdef MEM_PARITY_EN
               par_q[idx][b] <= (^wdata[8*b +: 8]) ^ inj_par_err;
`endif
            end
         end
      end
   end

   // Feed for each pipeline stage: stage 0 takes the new request, others shift.
   always_comb begin
      in_v[0]    = acc;
      in_rd[0]   = req_rd;
      in_code[0] = req_code;
      in_data[0] = req_data;
      for (int i = 1; i < RD_LATENCY; i++) begin
         in_v[i]    = pv_q[i-1];
         in_rd[i]   = prd_q[i-1];
         in_code[i] = pcode_q[i-1];
         in_data[i] = pdata_q[i-1];
      end
   end

   // Response shift pipeline; the last data stage only loads on a read response so rdata holds.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            pv_q[i]    <= 1'b0;
            prd_q[i]   <= 1'b0;
            pcode_q[i] <= 2'b00;
            pdata_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            pv_q[i]    <= in_v[i];
            prd_q[i]   <= in_rd[i];
            pcode_q[i] <= in_code[i];
            if ((i != RD_LATENCY - 1) || (in_v[i] && in_rd[i])) begin
               pdata_q[i] <= in_data[i];
            end
         end
      end
   end

   assign ready      = ready_q;
   assign resp_valid = pv_q[RD_LATENCY-1];
   assign resp_is_rd = prd_q[RD_LATENCY-1];
   assign resp       = pcode_q[RD_LATENCY-1];
   assign rdata      = pdata_q[RD_LATENCY-1];

endmodule

// File: tb/tb_mem_pipe_rtl.sv
// tb_mem_pipe_rtl: drives two mem_pipe_rtl instances (MEM_SIZE 16 and 12)
// with identical stimulus and compares each cycle against a word-level
// reference memory plus a queue of expected responses tagged with the clock
// edge on which they must appear.
module tb_mem_pipe_rtl;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int L  = 2;

   // Clock / reset block
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset_n;
   logic           wr;
   logic           rd;
   logic [AW-1:0]  addr;
   logic [DW-1:0]  wdata;
   logic [3:0]     wstrb;
   logic           inj_par_err;

   logic           a_ready, a_rv, a_ris;
   logic [1:0]     a_resp;
   logic [DW-1:0]  a_rdata;
   logic           b_ready, b_rv, b_ris;
   logic [1:0]     b_resp;
   logic [DW-1:0]  b_rdata;

   mem_pipe_rtl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(16), .RD_LATENCY(L)) dut_a (
      .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .addr(addr),
      .wdata(wdata), .wstrb(wstrb),
`ifdef MEM_PARITY_EN
      .inj_par_err(inj_par_err),
`endif
      .ready(a_ready), .resp_valid(a_rv), .resp_is_rd(a_ris),
      .resp(a_resp), .rdata(a_rdata)
   );

   mem_pipe_rtl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(12), .RD_LATENCY(L)) dut_b (
      .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .addr(addr),
      .wdata(wdata), .wstrb(wstrb),
`ifdef MEM_PARITY_EN
      .inj_par_err(inj_par_err),
`endif
      .ready(b_ready), .resp_valid(b_rv), .resp_is_rd(b_ris),
      .resp(b_resp), .rdata(b_rdata)
   );

   // Reference model and scoreboard
   typedef struct {
      int         due;
      logic       is_rd;
      logic [1:0] code;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q0[$];
   exp_t        exp_q1[$];
   logic [31:0] ref_mem [2][16];
   logic [3:0]  ref_bad [2][16];
   int          msize [2] = '{16, 12};
   int          edge_n;
   int          run_edges;
   int          n_checks;
   int          n_pass;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 16; i++) begin
            ref_mem[k][i] = '0;
            ref_bad[k][i] = '0;
         end
      exp_q0.delete();
      exp_q1.delete();
   endtask

   // Expected response for the request now on the inputs; accepted on the next edge.
   task automatic model_req(input int k, output exp_t e);
      e.due   = edge_n + L;
      e.is_rd = 1'b0;
      e.code  = 2'b00;
      e.data  = '0;
      if (wr && rd) begin
         e.code = 2'b11;
      end else if (int'(addr) >= msize[k]) begin
         e.code  = 2'b01;
         e.is_rd = rd;
      end else if (rd) begin
         e.is_rd = 1'b1;
         e.data  = ref_mem[k][addr];
         e.code  = (ref_bad[k][addr] != 4'h0) ? 2'b10 : 2'b00;
      end else begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b]) begin
               ref_mem[k][addr][8*b +: 8] = wdata[8*b +: 8];
               ref_bad[k][addr][b]        = inj_par_err;
            end
      end
   endtask

   task automatic check_outputs(input int k, input string nm, input logic rdy, input logic rv,
                                input logic ris, input logic [1:0] rs, input logic [31:0] rdat);
      exp_t e;
      bit   due;
      check({nm, " ready"}, rdy, run_edges >= 2);
      if (!reset_n) begin
         check({nm, " rst resp_valid"}, rv, 0);
         check({nm, " rst resp_is_rd"}, ris, 0);
         check({nm, " rst resp"}, rs, 0);
         check({nm, " rst rdata"}, rdat, 0);
      end else begin
         if (k == 0) due = (exp_q0.size() > 0) && (exp_q0[0].due == edge_n);
         else        due = (exp_q1.size() > 0) && (exp_q1[0].due == edge_n);
         check($sformatf("%s resp_valid@%0d", nm, edge_n), rv, due);
         if (due) begin
            if (k == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check($sformatf("%s resp_is_rd@%0d", nm, edge_n), ris, e.is_rd);
            check($sformatf("%s resp@%0d", nm, edge_n), rs, e.code);
            if (e.is_rd) check($sformatf("%s rdata@%0d", nm, edge_n), rdat, e.data);
         end
      end
   endtask

   // One clock: record the accepted request, advance, then check both DUTs.
   task automatic step();
      exp_t e;
      bit   acc;
      acc = reset_n && (run_edges >= 2) && (wr || rd);
      if (acc) begin
         model_req(0, e);
         exp_q0.push_back(e);
         model_req(1, e);
         exp_q1.push_back(e);
      end
      @(posedge clk);
      edge_n++;
      if (!reset_n) begin
         model_clear();
         run_edges = 0;
      end else begin
         run_edges++;
      end
      #1;
      check_outputs(0, "a", a_ready, a_rv, a_ris, a_resp, a_rdata);
      check_outputs(1, "b", b_ready, b_rv, b_ris, b_resp, b_rdata);
   endtask

   // Driver tasks
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         wr = 1'b0;
         rd = 1'b0;
         step();
      end
   endtask

   task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
      wr = 1'b1; rd = 1'b0; addr = a; wdata = d; wstrb = s;
      step();
   endtask

   task automatic do_rd(input logic [AW-1:0] a);
      wr = 1'b0; rd = 1'b1; addr = a;
      step();
   endtask

   task automatic do_illegal(input logic [AW-1:0] a);
      wr = 1'b1; rd = 1'b1; addr = a; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
      step();
   endtask

   task automatic reset_seq(input int n);
      reset_n = 1'b0;
      idle(n);
      reset_n = 1'b1;
      idle(2);
   endtask

   initial begin
      reset_n = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0;
      wdata = '0; wstrb = '0; inj_par_err = 1'b0;
      edge_n = 0; run_edges = 0; n_checks = 0; n_pass = 0;
      model_clear();

      // Reset and init sequence
      reset_seq(3);

      // Fill every address, then read back to back
      for (int i = 0; i < 16; i++) do_wr(AW'(i), DW'($urandom_range(10, 999)), 4'hF);
      for (int i = 0; i < 16; i++) do_rd(AW'(i));
      idle(L + 1);

      // Byte strobes: expected word is AA22CC44
      do_wr(4'd3, 32'hAABB_CCDD, 4'hF);
      do_wr(4'd3, 32'h1122_3344, 4'b0101);
      do_rd(4'd3);
      idle(L + 1);

      // Out of range on the 12-word instance, illegal wr&rd, then unchanged readback
      do_rd(4'd13);
      do_illegal(4'd2);
      do_rd(4'd2);
      idle(L + 1);

      // Reset mid-operation: in-flight requests disappear, memory returns to zero
      do_rd(4'd0);
      do_rd(4'd1);
      reset_seq(2);
      do_rd(4'd0);
      idle(L + 1);

      // Randomized mixed traffic including bubbles
      for (int i = 0; i < 300; i++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel <= 2)      idle(1);
         else if (sel <= 5) do_wr(AW'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
         else if (sel <= 8) do_rd(AW'($urandom_range(0, 15)));
         else               do_illegal(AW'($urandom_range(0, 15)));
      end
      idle(L + 1);

`ifdef MEM_PARITY_EN
      // Injected parity error, then a clean rewrite
      inj_par_err = 1'b1;
      do_wr(4'd1, 32'h5, 4'hF);
      inj_par_err = 1'b0;
      do_rd(4'd1);
      do_wr(4'd1, 32'h5, 4'hF);
      do_rd(4'd1);
      idle(L + 1);
`endif

      idle(L + 2);
      check("drain a", exp_q0.size(), 0);
      check("drain b", exp_q1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
